dff_bank_arbiter: RTL and testbench

DFF_BANK_ARBITER -- requirements
Module: dff_bank_arbiter

---
 rtl/dff_bank_arbiter.sv | 95 +++++++++
 tb/tb_dff_bank_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dff_bank_arbiter.sv
// rtl/dff_bank_arbiter.sv - four-requester round-robin arbiter guarding a shared register bank
module dff_bank_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [3:0]         req,
   input  logic [7:0]         cmd,
   input  logic [4*WIDTH-1:0] din,
   output logic [3:0]         gnt,
   output logic [3:0]         ack,
   output logic [WIDTH-1:0]   q,
   output logic [WIDTH-1:0]   qbar,
   output logic               busy
);

   typedef enum logic {IDLE, WRITE} state_t;

   state_t           state, state_n;
   logic [1:0]       ptr, ptr_n, win, win_n, pick, idx;
   logic [1:0]       cap_cmd, cap_cmd_n;
   logic [WIDTH-1:0] cap_din, cap_din_n, q_n;
   logic [3:0]       gnt_n, ack_n, elig;
   logic             found;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         ptr     <= 2'd0;
         q       <= '0;
         gnt     <= 4'd0;
         ack     <= 4'd0;
         win     <= 2'd0;
         cap_cmd <= 2'd0;
         cap_din <= '0;
      end else begin
         state   <= state_n;
         ptr     <= ptr_n;
         q       <= q_n;
         gnt     <= gnt_n;
         ack     <= ack_n;
         win     <= win_n;
         cap_cmd <= cap_cmd_n;
         cap_din <= cap_din_n;
      end
   end

   always_comb begin
      // a requester whose ack is showing this cycle has just been served
      elig  = req & ~ack;
      found = 1'b0;
      pick  = ptr;
      idx   = ptr;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && elig[idx]) begin
            found = 1'b1;
            pick  = idx;
         end
      end

      state_n   = state;
      ptr_n     = ptr;
      q_n       = q;
      gnt_n     = 4'd0;
      ack_n     = 4'd0;
      win_n     = win;
      cap_cmd_n = cap_cmd;
      cap_din_n = cap_din;

      if (state == IDLE) begin
         if (found) begin
            gnt_n     = 4'b0001 << pick;
            win_n     = pick;
            cap_cmd_n = cmd[{pick, 1'b0} +: 2];
            cap_din_n = din[WIDTH*int'(pick) +: WIDTH];
            state_n   = WRITE;
         end
      end else begin
         case (cap_cmd)
            2'b00:   q_n = cap_din;
            2'b01:   q_n = '1;
            2'b10:   q_n = '0;
            default: q_n = ~q;
         endcase
         ack_n[win] = 1'b1;
         ptr_n      = win + 2'd1;
         state_n    = IDLE;
      end
   end

   assign busy = (state == WRITE);
   assign qbar = ~q;

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb/tb_dff_bank_arbiter.sv - self-checking bench for dff_bank_arbiter
module tb_dff_bank_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req = 4'd0;
   logic [7:0]  cmd = 8'd0;
   logic [31:0] din = 32'd0;
   logic [3:0]  gnt, ack;
   logic [7:0]  q, qbar;
   logic        busy;

   int tests = 0;
   int fails = 0;

   dff_bank_arbiter #(.WIDTH(8)) dut (
      .clk(clk), .reset(reset), .req(req), .cmd(cmd), .din(din),
      .gnt(gnt), .ack(ack), .q(q), .qbar(qbar), .busy(busy)
   );

   always #5 clk = ~clk;

   // reference: a bank served round-robin, one pending transaction at a time
   logic [7:0] m_q = 8'd0;
   logic [3:0] m_gnt = 4'd0, m_ack = 4'd0;
   int         m_ptr = 0, m_win = 0;
   bit         m_write = 1'b0;
   logic [1:0] m_cmd = 2'd0;
   logic [7:0] m_din = 8'd0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_step(input logic r, input logic [3:0] rq, input logic [7:0] c,
                             input logic [31:0] d);
      logic [3:0] elig;
      if (r) begin
         m_write = 1'b0; m_ptr = 0; m_q = 8'd0; m_gnt = 4'd0; m_ack = 4'd0;
      end else if (m_write) begin
         case (m_cmd)
            2'b00: m_q = m_din;
            2'b01: m_q = 8'hFF;
            2'b10: m_q = 8'h00;
            default: m_q = ~m_q;
         endcase
         m_ack   = 4'd1 << m_win;
         m_gnt   = 4'd0;
         m_ptr   = (m_win + 1) % 4;
         m_write = 1'b0;
      end else begin
         elig  = rq & ~m_ack;
         m_ack = 4'd0;
         m_gnt = 4'd0;
         for (int k = 0; k < 4; k++) begin
            if (!m_write && elig[(m_ptr + k) % 4]) begin
               m_win   = (m_ptr + k) % 4;
               m_gnt   = 4'd1 << m_win;
               m_cmd   = 2'((c >> (2 * m_win)) & 8'h3);
               m_din   = 8'((d >> (8 * m_win)) & 32'hFF);
               m_write = 1'b1;
            end
         end
      end
   endtask

   task automatic cyc(input logic r, input logic [3:0] rq, input logic [7:0] c,
                      input logic [31:0] d);
      reset = r; req = rq; cmd = c; din = d;
      @(posedge clk);
      model_step(r, rq, c, d);
      #1;
      chk("gnt", {28'd0, gnt}, {28'd0, m_gnt});
      chk("ack", {28'd0, ack}, {28'd0, m_ack});
      chk("q", {24'd0, q}, {24'd0, m_q});
      chk("qbar", {24'd0, qbar}, {24'd0, ~m_q});
      chk("busy", {31'd0, busy}, {31'd0, m_write});
      chk("gnt_onehot", {31'd0, $countones(gnt) <= 1}, 32'd1);
      chk("ack_onehot", {31'd0, $countones(ack) <= 1}, 32'd1);
   endtask

   // hold req[i] until its ack shows, then release
   task automatic txn(input int i, input logic [1:0] c, input logic [7:0] d);
      logic [7:0]  cv;
      logic [31:0] dv;
      bit          done;
      cv = 8'(c) << (2 * i);
      dv = 32'(d) << (8 * i);
      done = 1'b0;
      for (int n = 0; n < 8 && !done; n++) begin
         cyc(1'b0, 4'd1 << i, cv, dv);
         if (m_ack[i]) done = 1'b1;
      end
      chk("txn_ack_seen", {31'd0, done}, 32'd1);
      cyc(1'b0, 4'd0, 8'd0, 32'd0);
   endtask

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [7:0]  cmd;
      logic [31:0] din;
      logic [3:0]  gnt;
      logic [3:0]  ack;
      logic [7:0]  q;
   } vec_t;

   vec_t vecs[$];

   initial begin
      logic [3:0] rq;
      vec_t       v;

      // single load, then four holders in strict rotation
      vecs.push_back('{1'b1, 4'h0, 8'h00, 32'h0000_0000, 4'h0, 4'h0, 8'h00});
      vecs.push_back('{1'b0, 4'h1, 8'h00, 32'h0000_00A5, 4'h1, 4'h0, 8'h00});
      vecs.push_back('{1'b0, 4'h1, 8'h00, 32'h0000_00A5, 4'h0, 4'h1, 8'hA5});
      vecs.push_back('{1'b0, 4'h0, 8'h00, 32'h0000_0000, 4'h0, 4'h0, 8'hA5});
      vecs.push_back('{1'b1, 4'h0, 8'h00, 32'h0000_0000, 4'h0, 4'h0, 8'h00});
      vecs.push_back('{1'b0, 4'hF, 8'h00, 32'h4433_2211, 4'h1, 4'h0, 8'h00});
      vecs.push_back('{1'b0, 4'hF, 8'h00, 32'h4433_2211, 4'h0, 4'h1, 8'h11});
      vecs.push_back('{1'b0, 4'hF, 8'h00, 32'h4433_2211, 4'h2, 4'h0, 8'h11});
      vecs.push_back('{1'b0, 4'hF, 8'h00, 32'h4433_2211, 4'h0, 4'h2, 8'h22});
      vecs.push_back('{1'b0, 4'hF, 8'h00, 32'h4433_2211, 4'h4, 4'h0, 8'h22});
      vecs.push_back('{1'b0, 4'hF, 8'h00, 32'h4433_2211, 4'h0, 4'h4, 8'h33});
      vecs.push_back('{1'b0, 4'hF, 8'h00, 32'h4433_2211, 4'h8, 4'h0, 8'h33});
      vecs.push_back('{1'b0, 4'hF, 8'h00, 32'h4433_2211, 4'h0, 4'h8, 8'h44});
      vecs.push_back('{1'b0, 4'hF, 8'h00, 32'h4433_2211, 4'h1, 4'h0, 8'h44});
      vecs.push_back('{1'b0, 4'hF, 8'h00, 32'h4433_2211, 4'h0, 4'h1, 8'h11});
      vecs.push_back('{1'b0, 4'h0, 8'h00, 32'h0000_0000, 4'h0, 4'h0, 8'h11});

      @(negedge clk);
      foreach (vecs[i]) begin
         v = vecs[i];
         cyc(v.rst, v.req, v.cmd, v.din);
         chk($sformatf("vec%0d_gnt", i), {28'd0, gnt}, {28'd0, v.gnt});
         chk($sformatf("vec%0d_ack", i), {28'd0, ack}, {28'd0, v.ack});
         chk($sformatf("vec%0d_q", i), {24'd0, q}, {24'd0, v.q});
      end

      // set, toggle, clear from requester 2
      cyc(1'b1, 4'd0, 8'd0, 32'd0);
      chk("cmds_q_init", {24'd0, q}, 32'h00);
      txn(2, 2'b01, 8'h00);
      chk("cmd01_q", {24'd0, q}, 32'hFF);
      chk("cmd01_qbar", {24'd0, qbar}, 32'h00);
      txn(2, 2'b11, 8'h00);
      chk("cmd11_q", {24'd0, q}, 32'h00);
      chk("cmd11_qbar", {24'd0, qbar}, 32'hFF);
      txn(2, 2'b10, 8'h00);
      chk("cmd10_q", {24'd0, q}, 32'h00);

      // req0 held through its ack while req1 waits
      cyc(1'b1, 4'd0, 8'd0, 32'd0);
      cyc(1'b0, 4'b0011, 8'd0, 32'h0000_2010);
      chk("hold_g0", {28'd0, gnt}, 32'h1);
      cyc(1'b0, 4'b0011, 8'd0, 32'h0000_2010);
      chk("hold_a0", {28'd0, ack}, 32'h1);
      cyc(1'b0, 4'b0011, 8'd0, 32'h0000_2010);
      chk("hold_g1_in_ack_cycle", {28'd0, gnt}, 32'h2);
      cyc(1'b0, 4'b0011, 8'd0, 32'h0000_2010);
      chk("hold_a1", {28'd0, ack}, 32'h2);
      cyc(1'b0, 4'b0001, 8'd0, 32'h0000_2010);
      chk("hold_g0_again", {28'd0, gnt}, 32'h1);
      cyc(1'b0, 4'b0000, 8'd0, 32'd0);

      // reset lands on a transaction in WRITE
      cyc(1'b1, 4'd0, 8'd0, 32'd0);
      cyc(1'b0, 4'b0100, 8'd0, 32'h003C_0000);
      chk("abort_busy", {31'd0, busy}, 32'd1);
      cyc(1'b1, 4'b0100, 8'd0, 32'h003C_0000);
      chk("abort_q", {24'd0, q}, 32'h00);
      chk("abort_no_ack", {28'd0, ack}, 32'h0);
      cyc(1'b0, 4'b0101, 8'd0, 32'h003C_0077);
      chk("abort_search_from0", {28'd0, gnt}, 32'h1);
      cyc(1'b0, 4'b0000, 8'd0, 32'd0);
      cyc(1'b0, 4'b0000, 8'd0, 32'd0);

      // inputs wiggling during WRITE are ignored
      cyc(1'b1, 4'd0, 8'd0, 32'd0);
      cyc(1'b0, 4'b0001, 8'h00, 32'h0000_0011);
      cyc(1'b0, 4'b0000, 8'h03, 32'h0000_0022);
      chk("inflight_q", {24'd0, q}, 32'h11);
      chk("inflight_ack", {28'd0, ack}, 32'h1);

      // randomized traffic with requests held until acknowledged
      rq = 4'd0;
      for (int n = 0; n < 400; n++) begin
         logic r;
         r = ($urandom_range(0, 49) == 0);
         for (int i = 0; i < 4; i++)
            if (!rq[i]) rq[i] = ($urandom_range(0, 2) == 0);
         cyc(r, rq, 8'($urandom), $urandom);
         for (int i = 0; i < 4; i++)
            if (m_ack[i] || r) rq[i] = 1'($urandom_range(0, 1));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
